// File: rtl/ps2_pkg.sv
// ps2_pkg: shared definitions for the PS/2 scan-code receiver.
//   - ps2_state_e     : frame FSM state encoding
//   - PS2_PREFIX_EXT  : extended-key prefix byte (E0)
//   - PS2_PREFIX_BRK  : break (key release) prefix byte (F0)
//   - PS2_FRAME_BITS  : bits per PS/2 frame (start, 8 data, parity, stop)
//   - odd_parity_ok() : true when data plus parity bit hold an odd number of ones
package ps2_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StData,
        StParity,
        StStop
    } ps2_state_e;

    localparam logic [7:0]  PS2_PREFIX_EXT = 8'hE0;
    localparam logic [7:0]  PS2_PREFIX_BRK = 8'hF0;
    localparam int unsigned PS2_FRAME_BITS = 11;
    // Frame minus start, parity and stop bits.
    localparam int unsigned PS2_DATA_BITS  = PS2_FRAME_BITS - 3;

    function automatic logic odd_parity_ok(input logic [7:0] data, input logic parity);
        return ^{parity, data};
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// ps2_line_filter: 2-FF synchronizer followed by a glitch filter for one PS/2 line.
// The filtered level only changes after FILTER_LEN consecutive synchronized samples
// disagree with it. Both stages reset to 1 (idle bus).
// Ports:
//   clk     - system clock
//   reset   - asynchronous active-low reset
//   i_line  - raw line, asynchronous to clk
//   o_level - filtered line level
//   o_fall  - one-cycle pulse in the first cycle o_level reads 0 after a 1->0 change
module ps2_line_filter #(
    parameter int unsigned FILTER_LEN = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic i_line,
    output logic o_level,
    output logic o_fall
);

    localparam int unsigned CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    logic [1:0]       r_sync_q;
    logic             r_level_q;
    logic             r_fall_q;
    logic [CNT_W-1:0] r_cnt_q;

    logic             w_level_d;
    logic             w_fall_d;
    logic [CNT_W-1:0] w_cnt_d;

    always_comb begin
        w_level_d = r_level_q;
        w_fall_d  = 1'b0;
        w_cnt_d   = '0;
        // Count consecutive disagreeing samples; any agreeing sample restarts the count.
        if (r_sync_q[1] != r_level_q) begin
            if (r_cnt_q == CNT_W'(FILTER_LEN - 1)) begin
                w_level_d = r_sync_q[1];
                w_fall_d  = r_level_q;
            end else begin
                w_cnt_d = r_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync_q  <= 2'b11;
            r_level_q <= 1'b1;
            r_fall_q  <= 1'b0;
            r_cnt_q   <= '0;
        end else begin
            r_sync_q  <= {r_sync_q[0], i_line};
            r_level_q <= w_level_d;
            r_fall_q  <= w_fall_d;
            r_cnt_q   <= w_cnt_d;
        end
    end

    assign o_level = r_level_q;
    assign o_fall  = r_fall_q;

endmodule

// File: rtl/ps2_scan_receiver.sv
// ps2_scan_receiver: receives PS/2 keyboard frames and reports key events with the
// E0 (extended) and F0 (break) prefixes stripped into flags.
// Optional feature macro: PS2_PARITY_CHECK_EN -- when defined, a frame with even
// parity is rejected; otherwise the parity bit is captured but never faulted.
// Ports:
//   clk         - system clock, rising edge
//   reset       - asynchronous active-low reset
//   ps2clk      - raw PS/2 clock (asynchronous)
//   ps2data     - raw PS/2 data (asynchronous)
//   scan_code   - last completed key-event code
//   released    - scan_code is a break event
//   extended    - scan_code was E0-prefixed
//   code_valid  - one-cycle pulse, scan_code/released/extended are new
//   frame_error - one-cycle pulse on start, parity, stop or timeout fault
//   busy        - frame in progress
module ps2_scan_receiver
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2clk,
    input  logic       ps2data,
    output logic [7:0] scan_code,
    output logic       released,
    output logic       extended,
    output logic       code_valid,
    output logic       frame_error,
    output logic       busy
);

    localparam int unsigned WDOG_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic w_clk_fall;
    logic w_data_level;
    logic w_unused_clk_level;
    logic w_unused_data_fall;

    ps2_line_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_clk_filter (
        .clk     (clk),
        .reset   (reset),
        .i_line  (ps2clk),
        .o_level (w_unused_clk_level),
        .o_fall  (w_clk_fall)
    );

    ps2_line_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_data_filter (
        .clk     (clk),
        .reset   (reset),
        .i_line  (ps2data),
        .o_level (w_data_level),
        .o_fall  (w_unused_data_fall)
    );

    ps2_state_e        r_state_q, w_state_d;
    logic [7:0]        r_shift_q, w_shift_d;
    logic [2:0]        r_bit_q, w_bit_d;
    logic              r_parity_q, w_parity_d;
    logic [WDOG_W-1:0] r_wdog_q, w_wdog_d;
    logic              r_pend_ext_q, w_pend_ext_d;
    logic              r_pend_brk_q, w_pend_brk_d;
    logic [7:0]        r_code_q, w_code_d;
    logic              r_released_q, w_released_d;
    logic              r_extended_q, w_extended_d;
    logic              r_code_valid_q, w_code_valid_d;
    logic              r_frame_error_q, w_frame_error_d;

    logic w_timeout;
    logic w_parity_fault;

    assign w_timeout = (r_state_q != StIdle) && (r_wdog_q == WDOG_W'(TIMEOUT_CYCLES - 1));

`ifdef PS2_PARITY_CHECK_EN
    assign w_parity_fault = !odd_parity_ok(r_shift_q, r_parity_q);
`else
    logic w_unused_parity;
    assign w_unused_parity = r_parity_q;
    assign w_parity_fault  = 1'b0;
`endif

    always_comb begin
        w_state_d       = r_state_q;
        w_shift_d       = r_shift_q;
        w_bit_d         = r_bit_q;
        w_parity_d      = r_parity_q;
        w_wdog_d        = (r_state_q == StIdle) ? '0 : r_wdog_q + 1'b1;
        w_pend_ext_d    = r_pend_ext_q;
        w_pend_brk_d    = r_pend_brk_q;
        w_code_d        = r_code_q;
        w_released_d    = r_released_q;
        w_extended_d    = r_extended_q;
        w_code_valid_d  = 1'b0;
        w_frame_error_d = 1'b0;

        // Timeout wins over a coincident falling edge; that edge is dropped.
        if (w_timeout) begin
            w_state_d       = StIdle;
            w_wdog_d        = '0;
            w_frame_error_d = 1'b1;
            w_pend_ext_d    = 1'b0;
            w_pend_brk_d    = 1'b0;
        end else if (w_clk_fall) begin
            w_wdog_d = '0;
            unique case (r_state_q)
                StIdle: begin
                    if (!w_data_level) begin
                        w_state_d = StData;
                        w_bit_d   = '0;
                    end else begin
                        w_frame_error_d = 1'b1;
                        w_pend_ext_d    = 1'b0;
                        w_pend_brk_d    = 1'b0;
                    end
                end
                StData: begin
                    w_shift_d = {w_data_level, r_shift_q[7:1]};
                    w_bit_d   = r_bit_q + 1'b1;
                    if (r_bit_q == 3'(PS2_DATA_BITS - 1)) begin
                        w_state_d = StParity;
                    end
                end
                StParity: begin
                    w_parity_d = w_data_level;
                    w_state_d  = StStop;
                end
                StStop: begin
                    w_state_d = StIdle;
                    if (!w_data_level || w_parity_fault) begin
                        w_frame_error_d = 1'b1;
                        w_pend_ext_d    = 1'b0;
                        w_pend_brk_d    = 1'b0;
                    end else if (r_shift_q == PS2_PREFIX_EXT) begin
                        w_pend_ext_d = 1'b1;
                    end else if (r_shift_q == PS2_PREFIX_BRK) begin
                        w_pend_brk_d = 1'b1;
                    end else begin
                        w_code_d       = r_shift_q;
                        w_released_d   = r_pend_brk_q;
                        w_extended_d   = r_pend_ext_q;
                        w_code_valid_d = 1'b1;
                        w_pend_ext_d   = 1'b0;
                        w_pend_brk_d   = 1'b0;
                    end
                end
                default: w_state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state_q       <= StIdle;
            r_shift_q       <= '0;
            r_bit_q         <= '0;
            r_parity_q      <= 1'b0;
            r_wdog_q        <= '0;
            r_pend_ext_q    <= 1'b0;
            r_pend_brk_q    <= 1'b0;
            r_code_q        <= '0;
            r_released_q    <= 1'b0;
            r_extended_q    <= 1'b0;
            r_code_valid_q  <= 1'b0;
            r_frame_error_q <= 1'b0;
        end else begin
            r_state_q       <= w_state_d;
            r_shift_q       <= w_shift_d;
            r_bit_q         <= w_bit_d;
            r_parity_q      <= w_parity_d;
            r_wdog_q        <= w_wdog_d;
            r_pend_ext_q    <= w_pend_ext_d;
            r_pend_brk_q    <= w_pend_brk_d;
            r_code_q        <= w_code_d;
            r_released_q    <= w_released_d;
            r_extended_q    <= w_extended_d;
            r_code_valid_q  <= w_code_valid_d;
            r_frame_error_q <= w_frame_error_d;
        end
    end

    assign scan_code   = r_code_q;
    assign released    = r_released_q;
    assign extended    = r_extended_q;
    assign code_valid  = r_code_valid_q;
    assign frame_error = r_frame_error_q;
    assign busy        = (r_state_q != StIdle);

endmodule

// File: tb/tb_ps2_scan_receiver.sv
// tb_ps2_scan_receiver: directed bench for ps2_scan_receiver with a scoreboard of
// expected key events compared against events captured from code_valid pulses.
module tb_ps2_scan_receiver;

    localparam int unsigned FLEN = 4;
    localparam int unsigned TMO  = 400;
    localparam int          HALF = 30;

    logic       clk;
    logic       reset;
    logic       ps2clk;
    logic       ps2data;
    logic [7:0] scan_code;
    logic       released;
    logic       extended;
    logic       code_valid;
    logic       frame_error;
    logic       busy;

    ps2_scan_receiver #(
        .FILTER_LEN     (FLEN),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .ps2clk      (ps2clk),
        .ps2data     (ps2data),
        .scan_code   (scan_code),
        .released    (released),
        .extended    (extended),
        .code_valid  (code_valid),
        .frame_error (frame_error),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [9:0] exp_q[$];
    logic [9:0] obs_q[$];
    int         n_err_pulse = 0;
    int         n_both      = 0;
    int         exp_err     = 0;
    logic [7:0] model_code  = 8'h00;
    logic       model_rel   = 1'b0;
    logic       model_ext   = 1'b0;

    always @(negedge clk) begin
        if (code_valid) obs_q.push_back({scan_code, released, extended});
        if (frame_error) n_err_pulse++;
        if (code_valid && frame_error) n_both++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic expect_code(input logic [7:0] code, input logic rel, input logic ext);
        exp_q.push_back({code, rel, ext});
        model_code = code;
        model_rel  = rel;
        model_ext  = ext;
    endtask

    function automatic logic [10:0] mk_frame(input logic [7:0] b, input logic good_par,
                                             input logic good_stop);
        logic par;
        par = good_par ? ~^b : ^b;
        return {good_stop, par, b, 1'b0};
    endfunction

    task automatic send_bits(input logic [10:0] bits, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            ps2data = bits[i];
            wait_clks(HALF);
            ps2clk = 1'b0;
            wait_clks(HALF);
            ps2clk = 1'b1;
        end
        ps2data = 1'b1;
        wait_clks(HALF);
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_bits(mk_frame(b, 1'b1, 1'b1), 11);
    endtask

    // Compare everything captured since the last drain against the scoreboard.
    task automatic drain(input string tag);
        logic [9:0] e;
        logic [9:0] o;
        wait_clks(10);
        @(negedge clk);
        check({tag, "_count"}, obs_q.size(), exp_q.size());
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            check({tag, "_code"}, o[9:2], e[9:2]);
            check({tag, "_rel"}, o[1], e[1]);
            check({tag, "_ext"}, o[0], e[0]);
        end
        exp_q.delete();
        obs_q.delete();
        check({tag, "_errs"}, n_err_pulse, exp_err);
        check({tag, "_hold_code"}, scan_code, model_code);
        check({tag, "_hold_rel"}, released, model_rel);
        check({tag, "_hold_ext"}, extended, model_ext);
        check({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        reset   = 1'b0;
        ps2clk  = 1'b1;
        ps2data = 1'b1;
        #23;
        #1;
        check("rst_code", scan_code, 0);
        check("rst_flags", {released, extended, code_valid, frame_error, busy}, 0);
        reset = 1'b1;
        wait_clks(20);

        // Plain make code.
        send_byte(8'h1C);
        expect_code(8'h1C, 1'b0, 1'b0);
        drain("plain_1C");

        // Break prefix alone yields no event.
        send_byte(8'hF0);
        drain("brk_prefix");
        send_byte(8'h1C);
        expect_code(8'h1C, 1'b1, 1'b0);
        drain("brk_1C");

        // Extended break, then plain code clears the flags.
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h75);
        expect_code(8'h75, 1'b1, 1'b1);
        drain("ext_brk_75");
        send_byte(8'h75);
        expect_code(8'h75, 1'b0, 1'b0);
        drain("plain_75");

        // Even parity.
        send_bits(mk_frame(8'h1C, 1'b0, 1'b1), 11);
`ifdef PS2_PARITY_CHECK_EN
        exp_err++;
`else
        expect_code(8'h1C, 1'b0, 1'b0);
`endif
        drain("bad_parity");

        // Short ps2clk glitch below the filter length is ignored.
        ps2clk = 1'b0;
        wait_clks(2);
        ps2clk = 1'b1;
        wait_clks(20);
        drain("glitch");

        // Bad stop bit faults and flushes a pending break prefix.
        send_byte(8'hF0);
        send_bits(mk_frame(8'h33, 1'b1, 1'b0), 11);
        exp_err++;
        drain("bad_stop");
        send_byte(8'h1C);
        expect_code(8'h1C, 1'b0, 1'b0);
        drain("after_stop_err");

        // Clock stops after the start bit and 4 data bits.
        send_bits(mk_frame(8'h29, 1'b1, 1'b1), 5);
        @(negedge clk);
        check("tmo_busy_mid", busy, 1);
        wait_clks(TMO + 100);
        exp_err++;
        drain("timeout");
        send_byte(8'h29);
        expect_code(8'h29, 1'b0, 1'b0);
        drain("after_tmo_29");

        // Reset mid-frame clears outputs without a clock edge.
        send_bits(mk_frame(8'h45, 1'b1, 1'b1), 5);
        @(negedge clk);
        check("rst_mid_busy_before", busy, 1);
        #2;
        reset = 1'b0;
        #1;
        check("rst_mid_code", scan_code, 0);
        check("rst_mid_flags", {released, extended, code_valid, frame_error, busy}, 0);
        model_code = 8'h00;
        model_rel  = 1'b0;
        model_ext  = 1'b0;
        wait_clks(5);
        reset = 1'b1;
        wait_clks(20);
        send_byte(8'h45);
        expect_code(8'h45, 1'b0, 1'b0);
        drain("after_rst_45");

        check("never_both", n_both, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ps2_scan_receiver.md
PS2_SCAN_RECEIVER -- requirements
Module: ps2_scan_receiver

Interface
REQ-001 SHALL have parameter FILTER_LEN, default 8: consecutive identical samples needed to accept a ps2clk/ps2data level change.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 50000: maximum clk cycles between falling ps2clk edges inside a frame.
REQ-003 SHALL have port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port ps2clk, input, 1: raw PS/2 clock from the keyboard, asynchronous to clk.
REQ-006 SHALL have port ps2data, input, 1: raw PS/2 data from the keyboard, asynchronous to clk.
REQ-007 SHALL have port scan_code, output, 8: last completed key-event code, with prefixes stripped.
REQ-008 SHALL have port released, output, 1: scan_code is a break event (preceded by F0).
REQ-009 SHALL have port extended, output, 1: scan_code was preceded by E0.
REQ-010 SHALL have port code_valid, output, 1: one-cycle pulse; scan_code, released and extended are new.
REQ-011 SHALL have port frame_error, output, 1: one-cycle pulse on a start, parity, stop or timeout fault.
REQ-012 SHALL have port busy, output, 1: high while a frame is in progress (any state except IDLE).

Function
REQ-013 SHALL pass each line through a 2-FF synchronizer, then the FILTER_LEN glitch filter; a ps2clk falling edge is a filtered 1->0 transition.
REQ-014 SHALL sample filtered ps2data only on a ps2clk falling edge.
REQ-015 SHALL run frame FSM IDLE -> DATA -> PARITY -> STOP -> IDLE:
  - IDLE -> DATA when the sampled bit is 0; a sampled 1 gives a start fault and stays in IDLE.
  - DATA shifts 8 bits in, LSB first.
  - PARITY captures the parity bit.
  - STOP checks the stop bit.
REQ-016 SHALL accept a frame only when the 8 data bits plus the parity bit are odd parity and the stop bit is 1; otherwise pulse frame_error and discard the byte.
REQ-017 SHALL treat byte E0 as a prefix that sets a pending-extended flag, with no code_valid.
REQ-018 SHALL treat byte F0 as a prefix that sets a pending-released flag, with no code_valid.
REQ-019 SHALL, on any other accepted byte:
  - load scan_code and load released/extended from the pending flags;
  - pulse code_valid;
  - clear both pending flags in the same cycle.
REQ-020 SHALL assert code_valid exactly 1 clk after the filtered falling edge that samples the stop bit.
REQ-021 SHALL hold scan_code, released and extended stable between code_valid pulses.
REQ-022 SHALL keep a watchdog counter that is cleared on every falling edge and counts only while not IDLE; reaching TIMEOUT_CYCLES-1 returns the FSM to IDLE, pulses frame_error, and clears the pending flags.
REQ-023 SHALL clear the pending flags on any frame_error.
REQ-024 SHALL let a timeout take precedence when it coincides with a falling edge in the same cycle; that edge is ignored.
REQ-025 SHALL never assert code_valid and frame_error in the same cycle.

Reset
REQ-026 SHALL, on reset low and without waiting for clk:
  - force FSM=IDLE;
  - set scan_code=0, released=0, extended=0, code_valid=0, frame_error=0, busy=0;
  - clear pending flags, watchdog and shift register;
  - set synchronizer and filter outputs to 1 (idle bus).
REQ-027 SHALL, when reset is asserted mid-frame, discard the partial frame; after release, the next frame must begin with a fresh start bit.

Configuration
REQ-028 SHALL compile parity checking only when macro PS2_PARITY_CHECK_EN is defined.
REQ-029 SHALL, without PS2_PARITY_CHECK_EN:
  - still capture the parity bit, but never treat it as a fault;
  - keep start and stop checks unconditional.

Structure
REQ-030 SHALL take from shared package ps2_pkg:
  - the FSM state enum;
  - constants PS2_PREFIX_EXT=8'hE0 and PS2_PREFIX_BRK=8'hF0;
  - frame-length constant 11.
REQ-031 SHALL implement synchronizer plus filter as sub-module ps2_line_filter (parameter FILTER_LEN), instantiated twice.

Verification
REQ-032 SHALL cover a valid frame for byte 1C -> one code_valid pulse, scan_code=1C, released=0, extended=0.
REQ-033 SHALL cover F0 then 1C -> one code_valid pulse only after 1C, scan_code=1C, released=1.
REQ-034 SHALL cover E0, F0, 75 -> scan_code=75, released=1, extended=1; a following plain 75 gives released=0, extended=0.
REQ-035 SHALL cover byte 1C sent with even parity -> with PS2_PARITY_CHECK_EN: frame_error pulse, no code_valid, outputs unchanged; without it: code_valid with scan_code=1C.
REQ-036 SHALL cover ps2clk stopping after 4 data bits for more than TIMEOUT_CYCLES -> frame_error pulse, busy=0; a following valid 29 frame gives scan_code=29.
REQ-037 SHALL cover reset driven low after 5 bits of a frame -> all outputs 0 immediately; a subsequent full valid 45 frame gives scan_code=45.
